// File: rtl/getc_unit.sv
// getc_unit: character-input unit for the ELVM CPU.
// Receives 8N1 UART frames on rx into a small byte FIFO. It answers CPU getc
// requests with a 9-bit register value and returns 0 at end-of-input once
// the FIFO has drained.
module getc_unit #(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   eof,
    input  logic                   getc_req,
    output logic                   getc_valid,
    output logic [8:0]             getc_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);
    localparam logic [AW-1:0] PTR_STEP  = AW'(1);
    localparam logic [AW:0]   OCC_STEP  = (AW + 1)'(1);
    localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    rx_state_t       state_nx;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            cnt_zero;
    logic            rx_push;
    logic            rx_bad;
    logic            shift_en;

    assign cnt_zero = (bit_cnt == '0);

    // Two-flop synchroniser; resets to the idle (mark) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // RX FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // RX FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_zero && (bit_idx == 3'd7)) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // RX FSM outputs: data shift strobe and stop-bit verdict.
    always_comb begin
        shift_en = 1'b0;
        rx_push  = 1'b0;
        rx_bad   = 1'b0;
        case (state)
            DATA:    shift_en = cnt_zero;
            STOP: begin
                rx_push = cnt_zero && rx_s;
                rx_bad  = cnt_zero && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit timer, bit index and data shift register (LSB first).
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= HALF_LOAD;
                end
                START: begin
                    if (cnt_zero) begin
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= '0;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_STEP;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_STEP;
                    end
                    if (shift_en) begin
                        shreg <= {rx_s, shreg[7:1]};
                    end
                end
                STOP: begin
                    if (!cnt_zero) begin
                        bit_cnt <= bit_cnt - CNT_STEP;
                    end
                end
                default: bit_cnt <= HALF_LOAD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO and request handling
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          pop;
    logic          eof_resp;
    logic          push_ok;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == OCC_FULL);

    // A request is re-evaluated every cycle it is held while no response is
    // on the bus, so a blocked read needs no separate pending register and a
    // dropped getc_req cancels it for free.
    assign accept   = getc_req && !getc_valid;
    assign pop      = accept && !fifo_empty;
    assign eof_resp = accept && fifo_empty && eof;
    assign push_ok  = rx_push && (!fifo_full || pop);

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + OCC_STEP;
                2'b01:   fifo_count <= fifo_count - OCC_STEP;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response strobe and held response value.
    always_ff @(posedge clk) begin
        if (rst) begin
            getc_valid <= 1'b0;
            getc_data  <= '0;
        end else begin
            getc_valid <= pop || eof_resp;
            if (pop) begin
                getc_data <= {1'b0, mem[rd_ptr]};
            end else if (eof_resp) begin
                getc_data <= '0;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_push && !push_ok) begin
                overrun <= 1'b1;
            end
            if (rx_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_getc_unit.sv
// Self-checking bench for getc_unit: directed UART frames and getc requests,
// with a byte-queue model of what every response must carry.
module tb_getc_unit;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       eof;
    logic       getc_req;
    logic       getc_valid;
    logic [8:0] getc_data;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       frame_err;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;

    logic [7:0] model_q[$];
    logic       exp_ov   = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       eof_seen = 1'b0;

    always #5 clk = ~clk;

    getc_unit #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .eof        (eof),
        .getc_req   (getc_req),
        .getc_valid (getc_valid),
        .getc_data  (getc_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_ov = 1'b0;
        exp_fe = 1'b0;
    endtask

    // Occupancy and sticky flags against the model at a quiet point.
    task automatic check_model(input string tag);
        check($sformatf("%s_count", tag), fifo_count, model_q.size());
        check($sformatf("%s_overrun", tag), overrun, exp_ov);
        check($sformatf("%s_frame_err", tag), frame_err, exp_fe);
    endtask

    // One 8N1 frame, 10 bit periods. The model records the byte up front;
    // only the order of bytes matters to it.
    task automatic send_frame(input logic [7:0] b, input logic good_stop);
        if (good_stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ov = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLK_DIV);
        end
        rx = good_stop;
        tick(CLK_DIV);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        tick(2 * CLK_DIV);
    endtask

    // Pulse getc_req for one cycle; the response is due right after that edge.
    task automatic do_read(input logic [8:0] exp, input string name);
        getc_req = 1'b1;
        tick(1);
        check($sformatf("%s_valid", name), getc_valid, 1'b1);
        check($sformatf("%s_data", name), getc_data, exp);
        getc_req = 1'b0;
        tick(1);
        check($sformatf("%s_valid_low", name), getc_valid, 1'b0);
    endtask

    // Compare process: every response must match the model queue head, or
    // be 0 when the model is empty and eof was seen.
    always @(negedge clk) begin
        logic [8:0] exp_data;
        if (rst !== 1'b1) begin
            check("data_bit8", getc_data[8], 1'b0);
            if (getc_valid === 1'b1) begin
                n_valid++;
                if (model_q.size() > 0) begin
                    exp_data = {1'b0, model_q.pop_front()};
                    check("model_data", getc_data, exp_data);
                end else if (eof_seen) begin
                    check("model_eof_zero", getc_data, 9'h000);
                end else begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got getc_valid=1 data=%0h, expected no response", getc_data);
                end
            end
        end
        eof_seen = eof;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        int nv;
        logic [8:0] exp9;

        rst = 1'b1; rx = 1'b1; eof = 1'b0; getc_req = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_valid", getc_valid, 1'b0);
        check("rst_data", getc_data, 9'h000);
        check("rst_count", fifo_count, 4'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);

        // Single byte: 2 sync + 9.5 bits + 1 push = 41 edges to fifo_count.
        send_frame(8'h41, 1'b1);
        check("w2f_before_push", fifo_count, 4'd0);
        tick(1);
        check("w2f_after_push", fifo_count, 4'd1);
        tick(2);
        do_read(9'h041, "single");
        check("single_count", fifo_count, 4'd0);

        // Blocking read: response exactly one edge after the push.
        getc_req = 1'b1;
        fork
            send_frame(8'h7A, 1'b1);
            begin
                int prev_cnt = 0;
                int cyc = 0;
                bit got = 0;
                while (!got && cyc < 200) begin
                    @(negedge clk);
                    if (getc_valid === 1'b1) begin
                        got = 1;
                        getc_req = 1'b0;
                        check("block_prev_count", prev_cnt, 1);
                        check("block_data", getc_data, 9'h07A);
                        check("block_latency", cyc, 42);
                    end
                    prev_cnt = fifo_count;
                    cyc++;
                end
                if (!got) begin
                    n_assert++;
                    n_fail++;
                    getc_req = 1'b0;
                    $display("FAIL block_timeout: got no getc_valid in 200 cycles, expected one");
                end
            end
        join
        tick(2 * CLK_DIV);
        check("block_count", fifo_count, 4'd0);

        // EOF with empty FIFO, then with one byte queued.
        eof = 1'b1;
        tick(1);
        do_read(9'h000, "eof_empty");
        check("eof_empty_count", fifo_count, 4'd0);
        eof = 1'b0;
        send_byte(8'h5C);
        eof = 1'b1;
        tick(1);
        do_read(9'h05C, "eof_byte_first");
        do_read(9'h000, "eof_then_zero");
        eof = 1'b0;

        // eof rising under a pending request answers one cycle later.
        getc_req = 1'b1;
        tick(3);
        check("pend_no_valid", getc_valid, 1'b0);
        eof = 1'b1;
        tick(1);
        check("eof_rise_valid", getc_valid, 1'b1);
        check("eof_rise_data", getc_data, 9'h000);
        getc_req = 1'b0;
        eof = 1'b0;
        tick(2);

        // Overrun: nine bytes into eight slots; pointers wrap on the way.
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
        end
        check("ovr_count", fifo_count, 4'd8);
        check("ovr_flag", overrun, 1'b1);
        check_model("ovr");
        for (int i = 1; i <= 8; i++) begin
            exp9 = {1'b0, 8'(i)};
            do_read(exp9, $sformatf("ovr_read%0d", i));
            check($sformatf("ovr_count_after%0d", i), fifo_count, 8 - i);
        end

        // Held request: at most one response every two cycles.
        send_byte(8'hA1);
        send_byte(8'hB2);
        getc_req = 1'b1;
        tick(1);
        check("b2b_v0", getc_valid, 1'b1);
        check("b2b_d0", getc_data, 9'h0A1);
        tick(1);
        check("b2b_gap", getc_valid, 1'b0);
        tick(1);
        check("b2b_v1", getc_valid, 1'b1);
        check("b2b_d1", getc_data, 9'h0B2);
        getc_req = 1'b0;
        tick(1);
        check("b2b_end", getc_valid, 1'b0);
        check("b2b_count", fifo_count, 4'd0);

        // One-cycle glitch: false start, no byte and no error.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(3 * CLK_DIV);
        check("glitch_count", fifo_count, 4'd0);
        check("glitch_frame_err", frame_err, 1'b0);

        // Cancelled request: nothing popped, no response.
        nv = n_valid;
        getc_req = 1'b1;
        tick(4);
        getc_req = 1'b0;
        tick(1);
        send_byte(8'h2B);
        check("cancel_no_valid", n_valid, nv);
        check("cancel_count", fifo_count, 4'd1);

        // Bad stop bit: sticky frame_err, FIFO untouched.
        send_frame(8'h55, 1'b0);
        tick(3 * CLK_DIV);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_count", fifo_count, 4'd1);
        check_model("ferr");

        // Reset during the high tail of 0xF0: partial byte lost, no resync.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                tick(6 * CLK_DIV + 2);
                rst = 1'b1;
                model_reset();
                tick(2);
                rst = 1'b0;
            end
        join
        check("mid_rst_valid", getc_valid, 1'b0);
        check("mid_rst_data", getc_data, 9'h000);
        check("mid_rst_count", fifo_count, 4'd0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        tick(3 * CLK_DIV);
        check("mid_rst_no_byte", fifo_count, 4'd0);
        send_byte(8'h33);
        check("post_rst_count", fifo_count, 4'd1);
        do_read(9'h033, "post_rst");

        // Reset while a request is pending: dropped, no response.
        nv = n_valid;
        getc_req = 1'b1;
        tick(2);
        rst = 1'b1;
        model_reset();
        tick(1);
        getc_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(4);
        check("rst_pend_no_valid", n_valid, nv);
        check_model("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
